// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - func3 encodings, FSM states and lane helpers for mem_stage
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // func3[1:0] is the access size for both loads and stores
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// rtl/mem_stage_align.sv - store lane placement and load byte-select/extension
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [2:0]  i_addr_lo,
    input  logic [63:0] i_store_data,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_wstrb,
    output logic [63:0] o_wdata,
    output logic [63:0] o_load_data
);

    logic [5:0]  w_shamt;
    logic [63:0] w_rshift;

    always_comb begin
        w_shamt  = {i_addr_lo, 3'b000};
        o_wstrb  = size_mask(i_func3[1:0]) << i_addr_lo;
        o_wdata  = i_store_data << w_shamt;
        w_rshift = i_rdata >> w_shamt;
        case (i_func3)
            F3_LB:   o_load_data = {{56{w_rshift[7]}},  w_rshift[7:0]};
            F3_LH:   o_load_data = {{48{w_rshift[15]}}, w_rshift[15:0]};
            F3_LW:   o_load_data = {{32{w_rshift[31]}}, w_rshift[31:0]};
            F3_LD:   o_load_data = w_rshift;
            F3_LBU:  o_load_data = {56'd0, w_rshift[7:0]};
            F3_LHU:  o_load_data = {48'd0, w_rshift[15:0]};
            F3_LWU:  o_load_data = {32'd0, w_rshift[31:0]};
            default: o_load_data = 64'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage with MEM/WB register, handshaked dmem access and stall
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [2:0]      func3_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] alu_input2_in,
    input  logic [4:0]      rd_in,
    input  logic            RegWrite_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic            MemReg_in,
    output logic            dmem_req,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] load_data_out,
    output logic [4:0]      rd_out,
    output logic            RegWrite_out,
    output logic            MemReg_out,
    output logic            valid_out,
    output logic            stall_out,
    output logic            mem_fault_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_alu;
    logic [4:0]      r_rd;
    logic [2:0]      r_func3;
    logic            r_regwrite;
    logic            r_memreg;
    logic            r_is_load;

    logic            w_mem_op;
    logic            w_misaligned;
    logic            w_illegal;
    logic            w_timeout;
    logic            w_done;
    logic [2:0]      w_func3;
    logic [2:0]      w_addr_lo;
    logic [7:0]      w_wstrb;
    logic [63:0]     w_wdata;
    logic [63:0]     w_load_data;

    always_comb begin
        w_mem_op = MemRead_in | MemWrite_in;
        case (func3_in[1:0])
            2'b01:   w_misaligned = alu_result_in[0];
            2'b10:   w_misaligned = |alu_result_in[1:0];
            2'b11:   w_misaligned = |alu_result_in[2:0];
            default: w_misaligned = 1'b0;
        endcase
        w_illegal = w_mem_op & (w_misaligned
                              | (MemRead_in & MemWrite_in)
                              | (MemRead_in & (func3_in == 3'b111))
                              | (MemWrite_in & func3_in[2]));
        w_timeout = (TIMEOUT != 0) && (r_count == LAST);
        w_done    = dmem_ready | w_timeout;
        // The aligner serves stores while idle and load extraction while busy
        w_func3   = (r_state == ST_BUSY) ? r_func3   : func3_in;
        w_addr_lo = (r_state == ST_BUSY) ? r_alu[2:0] : alu_result_in[2:0];
    end

    mem_align u_align (
        .i_func3      (w_func3),
        .i_addr_lo    (w_addr_lo),
        .i_store_data (alu_input2_in),
        .i_rdata      (dmem_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mem_op && !w_illegal) w_next = ST_BUSY;
            ST_BUSY: if (w_done)                 w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_out = (r_state == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= '0;
            r_pc           <= '0;
            r_alu          <= '0;
            r_rd           <= '0;
            r_func3        <= '0;
            r_regwrite     <= 1'b0;
            r_memreg       <= 1'b0;
            r_is_load      <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            pc_out         <= '0;
            alu_result_out <= '0;
            load_data_out  <= '0;
            rd_out         <= '0;
            RegWrite_out   <= 1'b0;
            MemReg_out     <= 1'b0;
            valid_out      <= 1'b0;
            mem_fault_out  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_count <= '0;
            if (!w_mem_op || w_illegal) begin
                pc_out         <= pc_in;
                alu_result_out <= alu_result_in;
                load_data_out  <= '0;
                rd_out         <= rd_in;
                RegWrite_out   <= RegWrite_in & ~w_illegal;
                MemReg_out     <= MemReg_in;
                valid_out      <= 1'b1;
                mem_fault_out  <= w_illegal;
                dmem_req       <= 1'b0;
            end else begin
                r_pc          <= pc_in;
                r_alu         <= alu_result_in;
                r_rd          <= rd_in;
                r_func3       <= func3_in;
                r_regwrite    <= RegWrite_in;
                r_memreg      <= MemReg_in;
                r_is_load     <= MemRead_in;
                dmem_req      <= 1'b1;
                dmem_addr     <= {alu_result_in[XLEN-1:3], 3'b000};
                dmem_wstrb    <= MemWrite_in ? w_wstrb : 8'h00;
                dmem_wdata    <= MemWrite_in ? w_wdata : '0;
                valid_out     <= 1'b0;
                mem_fault_out <= 1'b0;
            end
        end else if (w_done) begin
            // dmem_ready wins over a timeout landing in the same cycle
            pc_out         <= r_pc;
            alu_result_out <= r_alu;
            load_data_out  <= (dmem_ready && r_is_load) ? w_load_data : '0;
            rd_out         <= r_rd;
            RegWrite_out   <= r_regwrite & dmem_ready;
            MemReg_out     <= r_memreg;
            valid_out      <= 1'b1;
            mem_fault_out  <= ~dmem_ready;
            dmem_req       <= 1'b0;
            dmem_wstrb     <= 8'h00;
        end else begin
            r_count       <= r_count + 1'b1;
            valid_out     <= 1'b0;
            mem_fault_out <= 1'b0;
        end
    end

endmodule

// File: doc/mem_stage.md
Name:
mem_stage

Overview:
Memory-access stage sitting directly downstream of ex_mem_reg, including the MEM/WB pipeline register. Performs loads and stores against a handshaked data memory, with RV64 byte/half/word/double sizing and sign/zero extension. Stalls the pipeline while an access is outstanding.

Parameters:
XLEN, 64, datapath width (only 64 supported)
TIMEOUT, 256, max cycles waiting on dmem_ready before fault (0 = never)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pc_in  in  64  pc from ex_mem
func3_in  in  3  access size/sign
alu_result_in  in  64  effective address, or ALU result for non-memory ops
alu_input2_in  in  64  store data (rs2)
rd_in  in  5  destination register
RegWrite_in  in  1  writeback enable
MemRead_in  in  1  load
MemWrite_in  in  1  store
MemReg_in  in  1  writeback selects memory data
dmem_req  out  1  memory request, registered, held until ready
dmem_addr  out  64  8-byte-aligned address (alu_result[63:3],3'b0)
dmem_wdata  out  64  store data shifted into byte lanes
dmem_wstrb  out  8  byte write strobes; all-zero = read
dmem_ready  in  1  access complete this cycle
dmem_rdata  in  64  read data, valid when dmem_ready
pc_out  out  64  to WB
alu_result_out  out  64  to WB
load_data_out  out  64  extended load data
rd_out  out  5  to WB
RegWrite_out  out  1  to WB
MemReg_out  out  1  to WB
valid_out  out  1  WB slot holds a real instruction
stall_out  out  1  to hazard unit; freeze IF..EX and hold ex_mem contents
mem_fault_out  out  1  misaligned/illegal/timeout, one-cycle pulse with valid_out

Behaviour:
- Clock is clk; reset is synchronous, active-high. On reset: all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-access abandons it; dmem_req is low after the reset edge.
- FSM states IDLE, BUSY. stall_out = (state==BUSY), combinational from state.
- IDLE, no mem op: next edge registers the inputs to the outputs; valid_out=1; load_data_out=0. Latency 1 cycle.
- IDLE, mem op, aligned and legal: capture address, func3, rd, control and data; assert dmem_req; go BUSY; valid_out=0 (bubble).
- Alignment: H needs addr[0]==0, W needs addr[1:0]==0, D needs addr[2:0]==0. Load func3 111 or store func3 >=100 is illegal. On fault: no request issued; outputs register with RegWrite_out=0, valid_out=1 and mem_fault_out=1 for one cycle; stay IDLE.
- MemRead and MemWrite both set: treat as illegal.
- Store lanes: wstrb = size mask << addr[2:0]; wdata = rs2 << (8*addr[2:0]).
- BUSY: inputs ignored; dmem_req, addr, wdata and wstrb held stable. On dmem_ready the next edge:
  - loads: byte-select from dmem_rdata using captured addr[2:0]; extend per func3 (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU).
  - write outputs, valid_out=1, drop dmem_req, return to IDLE.
- Ready and a new op in the same cycle: the new op is held upstream by stall_out and accepted next cycle in IDLE. Throughput is one mem op per 2 cycles minimum.
- Timeout: the counter increments each BUSY cycle. Reaching TIMEOUT without ready produces a fault, as for misalignment, then IDLE. A dmem_ready that arrives late in IDLE is ignored.

Decomposition:
- Shared package: func3 encodings (LB..LWU, SB..SD) and FSM state encoding.
- One sub-module: mem_align (combinational) computes wstrb, wdata shift and load extract/extend.

Test Plan:
- ADD passthrough: alu_result_in=0x1234, rd=5, RegWrite=1 -> next cycle alu_result_out=0x1234, rd_out=5, valid_out=1, stall_out=0.
- LB with addr=0x1003, rdata=0x00000000_80000000 (byte3=0x80) -> dmem_addr=0x1000, wstrb=0; after ready load_data_out=0xFFFFFFFF_FFFFFF80. LBU on the same data -> 0x80.
- SH with addr=0x2006, rs2=0xABCD, ready after 3 cycles -> wstrb=0xC0, wdata[63:48]=0xABCD, stall_out high 3 cycles, one valid_out pulse.
- LW with addr=0x3002 -> no dmem_req, mem_fault_out=1, RegWrite_out=0, valid_out=1 for one cycle.
- TIMEOUT=4, dmem_ready never asserted -> fault on the 4th BUSY cycle, then IDLE. Reset asserted during BUSY -> dmem_req=0 and all outputs 0 the next cycle.
